// File: rtl/gate_truth_table_checker.sv
// Sweep engine for a single-output combinational gate: walks every input vector,
// lets it settle, samples the gate output and tallies mismatches against the truth table.
module gate_truth_table_checker #(
    parameter int N_IN    = 2,
    parameter int GATE_OP = 0,
    parameter int SETTLE  = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            dut_out,
    output logic [N_IN-1:0] dut_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] fail_vec
);

    localparam int            CW       = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [N_IN-1:0]   dut_in_nxt, fail_vec_nxt;
    logic [N_IN:0]     err_count_nxt, err_new;
    logic              busy_nxt, done_nxt, pass_nxt, fail_valid_nxt;
    logic              exp_bit, mismatch;

    // GATE_OP values above 5 are misuse; the expected value is then constant 0.
    function automatic logic gate_fn(input logic [N_IN-1:0] v);
        case (GATE_OP)
            0:       return &v;
            1:       return |v;
            2:       return ^v;
            3:       return ~&v;
            4:       return ~|v;
            5:       return ~^v;
            default: return 1'b0;
        endcase
    endfunction

    assign exp_bit  = gate_fn(dut_in);
    // Case inequality so an X/Z gate output is scored as a mismatch.
    assign mismatch = (dut_out !== exp_bit);
    assign err_new  = err_count + (N_IN+1)'(mismatch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            dut_in     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            dut_in     <= dut_in_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            pass       <= pass_nxt;
            err_count  <= err_count_nxt;
            fail_valid <= fail_valid_nxt;
            fail_vec   <= fail_vec_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        dut_in_nxt     = dut_in;
        busy_nxt       = busy;
        done_nxt       = done;
        pass_nxt       = pass;
        err_count_nxt  = err_count;
        fail_valid_nxt = fail_valid;
        fail_vec_nxt   = fail_vec;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt      = S_WAIT;
                    cnt_nxt        = CNT_INIT;
                    dut_in_nxt     = '0;
                    busy_nxt       = 1'b1;
                    done_nxt       = 1'b0;
                    pass_nxt       = 1'b0;
                    err_count_nxt  = '0;
                    fail_valid_nxt = 1'b0;
                    fail_vec_nxt   = '0;
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1))
                    state_nxt = S_CHECK;
            end
            S_CHECK: begin
                err_count_nxt = err_new;
                if (mismatch && !fail_valid) begin
                    fail_valid_nxt = 1'b1;
                    fail_vec_nxt   = dut_in;
                end
                if (&dut_in) begin
                    state_nxt = S_DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    pass_nxt  = (err_new == '0);
                end else begin
                    state_nxt  = S_WAIT;
                    dut_in_nxt = dut_in + N_IN'(1);
                    cnt_nxt    = CNT_INIT;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Directed bench: 2-input AND checker (SETTLE=3) and 3-input XOR checker (SETTLE=1)
// driven by behavioural gate models with injectable faults.
module tb_gate_truth_table_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT A: N_IN=2, AND, SETTLE=3
    logic       rst_n, start_a, dut_out_a;
    logic [1:0] dut_in_a, fail_vec_a;
    logic [2:0] err_a;
    logic       busy_a, done_a, pass_a, fv_a;
    int         mode_a;  // 0 correct AND, 1 stuck-at-0, 2 NAND

    // DUT B: N_IN=3, XOR, SETTLE=1
    logic       start_b, dut_out_b;
    logic [2:0] dut_in_b, fail_vec_b;
    logic [3:0] err_b;
    logic       busy_b, done_b, pass_b, fv_b;
    int         mode_b;  // 0 correct XOR, 1 X output (inverted XOR on 2-state sims)
    logic       xprobe;
    bit         x_ok;

    gate_truth_table_checker #(.N_IN(2), .GATE_OP(0), .SETTLE(3)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .dut_out(dut_out_a),
        .dut_in(dut_in_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .fail_valid(fv_a), .fail_vec(fail_vec_a));

    gate_truth_table_checker #(.N_IN(3), .GATE_OP(2), .SETTLE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .dut_out(dut_out_b),
        .dut_in(dut_in_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .fail_valid(fv_b), .fail_vec(fail_vec_b));

    always_comb begin
        case (mode_a)
            1:       dut_out_a = 1'b0;
            2:       dut_out_a = ~(&dut_in_a);
            default: dut_out_a = &dut_in_a;
        endcase
    end

    always_comb begin
        if (mode_b == 1) dut_out_b = x_ok ? 1'bx : ~(^dut_in_b);
        else             dut_out_b = ^dut_in_b;
    end

    typedef struct {
        int         mode;
        int         poke;      // cycle at which start is pulsed mid-sweep, -1 none
        logic [2:0] exp_err;
        logic       exp_pass;
        logic       exp_fv;
        logic [1:0] exp_vec;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at the negedge right after the start-sampling edge.
    task automatic body_a(input int poke);
        for (int c = 0; c < 16; c++) begin
            chk("a_dut_in", dut_in_a, c / 4);
            chk("a_busy", busy_a, 1);
            chk("a_done", done_a, 0);
            if (c == poke) start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
        end
        chk("a_done_end", done_a, 1);
        chk("a_busy_end", busy_a, 0);
    endtask

    task automatic sweep_a(input int poke);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        body_a(poke);
    endtask

    task automatic sweep_b();
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int c = 0; c < 16; c++) begin
            chk("b_dut_in", dut_in_b, c / 2);
            chk("b_busy", busy_b, 1);
            @(negedge clk);
        end
        chk("b_done_end", done_b, 1);
    endtask

    initial begin
        tbl[0] = '{mode: 0, poke: -1, exp_err: 3'd0, exp_pass: 1'b1, exp_fv: 1'b0, exp_vec: 2'b00};
        tbl[1] = '{mode: 1, poke: -1, exp_err: 3'd1, exp_pass: 1'b0, exp_fv: 1'b1, exp_vec: 2'b11};
        tbl[2] = '{mode: 2, poke: -1, exp_err: 3'd4, exp_pass: 1'b0, exp_fv: 1'b1, exp_vec: 2'b00};
        tbl[3] = '{mode: 0, poke:  5, exp_err: 3'd0, exp_pass: 1'b1, exp_fv: 1'b0, exp_vec: 2'b00};

        xprobe  = 1'bx;
        x_ok    = $isunknown(xprobe);
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        mode_a  = 0;
        mode_b  = 0;
        repeat (2) @(negedge clk);
        chk("rst_a_outs", {dut_in_a, busy_a, done_a, pass_a, err_a, fv_a, fail_vec_a}, 0);
        chk("rst_b_outs", {dut_in_b, busy_b, done_b, pass_b, err_b, fv_b, fail_vec_b}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_hold", {busy_a, done_a}, 0);

        foreach (tbl[i]) begin
            mode_a = tbl[i].mode;
            sweep_a(tbl[i].poke);
            chk("a_err", err_a, tbl[i].exp_err);
            chk("a_pass", pass_a, tbl[i].exp_pass);
            chk("a_fv", fv_a, tbl[i].exp_fv);
            chk("a_fvec", fail_vec_a, tbl[i].exp_vec);
            @(negedge clk);
            chk("a_done_hold", {done_a, err_a}, {1'b1, tbl[i].exp_err});
        end

        // Restart from DONE after a failing sweep clears results.
        mode_a = 1;
        sweep_a(-1);
        chk("a_pre_restart_err", err_a, 1);
        mode_a  = 0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("a_restart_done", done_a, 0);
        chk("a_restart_err", err_a, 0);
        chk("a_restart_fv", fv_a, 0);
        body_a(-1);
        chk("a_restart_pass", pass_a, 1);

        // Async reset mid-sweep while vector 10 is settling.
        mode_a  = 2;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (8) @(negedge clk);
        chk("a_mid_vec", dut_in_a, 2'b10);
        chk("a_mid_err", err_a, 2);
        rst_n = 1'b0;
        #1;
        chk("a_async_rst", {dut_in_a, busy_a, done_a, pass_a, err_a, fv_a, fail_vec_a}, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        mode_a = 0;
        @(negedge clk);
        sweep_a(-1);
        chk("a_post_rst_pass", pass_a, 1);
        chk("a_post_rst_err", err_a, 0);

        // 3-input XOR checker
        mode_b = 0;
        sweep_b();
        chk("b_pass", pass_b, 1);
        chk("b_err", err_b, 0);
        mode_b = 1;
        @(negedge clk);
        sweep_b();
        chk("b_bad_err", err_b, 8);
        chk("b_bad_fvec", fail_vec_b, 0);
        chk("b_bad_pass", pass_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
